bcd_divider_seq: RTL and testbench

Sequential decimal digit-recurrence divider. It is the inverse operation of the team's parallel 4x4-digit BCD multiplier. It takes an 8-digit BCD dividend and a 4-digit BCD divisor, and returns an 8-digit BCD quotient and a 4-digit BCD remainder. It sits beside the multiplier in the decimal arithmetic unit and uses a start/done handshake. All internal arithmetic stays in BCD; there is no binary conversion.

---
 rtl/bcd_divider_seq.sv | 209 ++++++++++++++++++++
 tb/tb_bcd_divider_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_divider_seq.sv
// Sequential BCD digit-recurrence divider: one quotient digit per SHIFT plus
// repeated SUB passes, with all partial-remainder arithmetic kept in BCD.
module bcd_divider_seq #(
  parameter int N_DIGITS = 8,
  parameter int D_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*N_DIGITS-1:0] dividend_bcd,
  input  logic [4*D_DIGITS-1:0] divisor_bcd,
  output logic                  busy,
  output logic                  done,
  output logic [4*N_DIGITS-1:0] quotient_bcd,
  output logic [4*D_DIGITS-1:0] remainder_bcd,
  output logic                  err_div0,
  output logic                  err_digit
);

  localparam int NW = 4 * N_DIGITS;
  localparam int DW = 4 * D_DIGITS;
  localparam int RW = 4 * (D_DIGITS + 1);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SHIFT,
    S_SUB,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [NW-1:0] dvd_q, dvd_d;
  logic [DW-1:0] dvs_q, dvs_d;
  logic [RW-1:0] r_q, r_d;
  logic [NW-1:0] qsr_q, qsr_d;
  logic [3:0]    q_q, q_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          fdiv0_q, fdiv0_d;
  logic          fdig_q, fdig_d;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [NW-1:0] quot_q, quot_d;
  logic [DW-1:0] rem_q, rem_d;
  logic          ediv0_q, ediv0_d;
  logic          edig_q, edig_d;

  logic          bad_c;
  logic          zero_c;
  logic          ge_c;
  logic [RW-1:0] dvs_ext;
  logic [RW-1:0] r_shift;
  logic [RW-1:0] r_sub;

  assign dvs_ext = {4'h0, dvs_q};
  assign r_shift = {r_q[RW-5:0], dvd_q[NW-1 -: 4]};
  // Packed BCD with legal digits orders the same as plain unsigned binary.
  assign ge_c    = (r_q >= dvs_ext);
  assign zero_c  = (dvs_q == '0);

  always_comb begin
    bad_c = 1'b0;
    for (int unsigned i = 0; i < N_DIGITS; i++)
      if (dvd_q[4*i +: 4] > 4'd9) bad_c = 1'b1;
    for (int unsigned i = 0; i < D_DIGITS; i++)
      if (dvs_q[4*i +: 4] > 4'd9) bad_c = 1'b1;
  end

  // Ten's-complement subtract: R + (nines-complement of divisor) + 1, carry dropped.
  always_comb begin : bcd_sub
    logic [4:0] s;
    logic       c;
    r_sub = '0;
    c     = 1'b1;
    for (int unsigned i = 0; i < D_DIGITS + 1; i++) begin
      s = {1'b0, r_q[4*i +: 4]} + {1'b0, 4'd9 - dvs_ext[4*i +: 4]} + {4'd0, c};
      if (s > 5'd9) begin
        s = s - 5'd10;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r_sub[4*i +: 4] = s[3:0];
    end
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    r_d     = r_q;
    qsr_d   = qsr_q;
    q_d     = q_q;
    idx_d   = idx_q;
    fdiv0_d = fdiv0_q;
    fdig_d  = fdig_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CHECK;
          dvd_d   = dividend_bcd;
          dvs_d   = divisor_bcd;
          r_d     = '0;
          qsr_d   = '0;
          q_d     = '0;
          idx_d   = '0;
          fdiv0_d = 1'b0;
          fdig_d  = 1'b0;
        end
      end
      S_CHECK: begin
        // Error flags are registered first and acted on the following cycle.
        if (fdiv0_q || fdig_q) begin
          state_d = S_DONE;
        end else if (zero_c || bad_c) begin
          fdiv0_d = zero_c;
          fdig_d  = bad_c;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        r_d     = r_shift;
        dvd_d   = {dvd_q[NW-5:0], 4'h0};
        q_d     = '0;
        state_d = S_SUB;
      end
      S_SUB: begin
        if (ge_c) begin
          r_d = r_sub;
          q_d = q_q + 4'd1;
        end else begin
          qsr_d = {qsr_q[NW-5:0], q_q};
          if (idx_q == IW'(N_DIGITS - 1)) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_SHIFT;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Result registers load on entry to DONE so they are valid alongside done.
  always_comb begin
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    quot_d  = quot_q;
    rem_d   = rem_q;
    ediv0_d = ediv0_q;
    edig_d  = edig_q;
    if (state_d == S_DONE) begin
      quot_d  = qsr_d;
      rem_d   = r_d[DW-1:0];
      ediv0_d = fdiv0_d;
      edig_d  = fdig_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      r_q     <= '0;
      qsr_q   <= '0;
      q_q     <= '0;
      idx_q   <= '0;
      fdiv0_q <= 1'b0;
      fdig_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      ediv0_q <= 1'b0;
      edig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      r_q     <= r_d;
      qsr_q   <= qsr_d;
      q_q     <= q_d;
      idx_q   <= idx_d;
      fdiv0_q <= fdiv0_d;
      fdig_q  <= fdig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      ediv0_q <= ediv0_d;
      edig_q  <= edig_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign quotient_bcd  = quot_q;
  assign remainder_bcd = rem_q;
  assign err_div0      = ediv0_q;
  assign err_digit     = edig_q;

endmodule

// File: tb/tb_bcd_divider_seq.sv
// Self-checking bench for bcd_divider_seq: integer-arithmetic reference model
// compared every cycle, plus directed and randomized operations.
module tb_bcd_divider_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend_bcd = '0;
  logic [15:0] divisor_bcd = '0;
  logic        busy, done, err_div0, err_digit;
  logic [31:0] quotient_bcd;
  logic [15:0] remainder_bcd;

  bcd_divider_seq #(.N_DIGITS(8), .D_DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dividend_bcd(dividend_bcd), .divisor_bcd(divisor_bcd),
    .busy(busy), .done(done),
    .quotient_bcd(quotient_bcd), .remainder_bcd(remainder_bcd),
    .err_div0(err_div0), .err_digit(err_digit)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic int unsigned bcd2int(input logic [31:0] b);
    int unsigned v = 0;
    for (int i = 7; i >= 0; i--) v = v * 10 + 32'(b[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [31:0] int2bcd(input int unsigned v);
    logic [31:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [31:0] a, input logic [15:0] b);
    bit bad = 0;
    for (int i = 0; i < 8; i++) if (a[4*i +: 4] > 4'd9) bad = 1;
    for (int i = 0; i < 4; i++) if (b[4*i +: 4] > 4'd9) bad = 1;
    return bad;
  endfunction

  task automatic model_op(input logic [31:0] dvd, input logic [15:0] dvs,
                          output logic [31:0] q, output logic [15:0] r,
                          output logic e0, output logic ed, output int lat);
    int unsigned qi, ri;
    e0 = (dvs == 16'h0);
    ed = has_bad(dvd, dvs);
    if (e0 || ed) begin
      q = '0; r = '0; lat = 2;
    end else begin
      qi = bcd2int(dvd) / bcd2int({16'h0, dvs});
      ri = bcd2int(dvd) % bcd2int({16'h0, dvs});
      q = int2bcd(qi);
      r = int2bcd(ri) & 32'h0000_FFFF;
      lat = 17;
      for (int i = 0; i < 8; i++) lat += int'(q[4*i +: 4]);
    end
  endtask

  // Reference model: phase of the current operation plus expected outputs.
  typedef enum {M_IDLE, M_RUN, M_DONE} mph_t;
  mph_t        ph = M_IDLE;
  bit          model_on = 0;
  logic        exp_busy = 0, exp_done = 0, exp_e0 = 0, exp_ed = 0;
  logic [31:0] exp_q = '0, pq;
  logic [15:0] exp_r = '0, pr;
  logic        pe0, ped;
  int          m_rem;

  always @(posedge clk) begin
    if (!rst_n) begin
      ph = M_IDLE; model_on = 1;
      exp_busy = 0; exp_done = 0; exp_e0 = 0; exp_ed = 0; exp_q = '0; exp_r = '0;
    end else begin
      case (ph)
        M_IDLE: if (start) begin
          model_op(dividend_bcd, divisor_bcd, pq, pr, pe0, ped, m_rem);
          ph = M_RUN; exp_busy = 1;
        end
        M_RUN: begin
          m_rem--;
          if (m_rem == 0) begin
            exp_done = 1; exp_q = pq; exp_r = pr; exp_e0 = pe0; exp_ed = ped;
            ph = M_DONE;
          end
        end
        M_DONE: begin
          exp_done = 0; exp_busy = 0; ph = M_IDLE;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("done", 64'(done), 64'(exp_done));
      chk("quotient", 64'(quotient_bcd), 64'(exp_q));
      chk("remainder", 64'(remainder_bcd), 64'(exp_r));
      chk("err_div0", 64'(err_div0), 64'(exp_e0));
      chk("err_digit", 64'(err_digit), 64'(exp_ed));
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 300) begin @(negedge clk); n++; end
    chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic run_op(input logic [31:0] dvd, input logic [15:0] dvs,
                        input logic [31:0] eq, input logic [15:0] er,
                        input logic e0, input logic ed, input int elat);
    int  lat = 0;
    bit  got = 0;
    wait_idle();
    dividend_bcd = dvd; divisor_bcd = dvs; start = 1;
    @(posedge clk);
    #1 start = 0; dividend_bcd = $urandom; divisor_bcd = 16'($urandom);
    while (lat < 200) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
      lat++;
    end
    chk("done_seen", 64'(got), 64'd1);
    chk("latency", 64'(lat), 64'(elat));
    chk("op_quot", 64'(quotient_bcd), 64'(eq));
    chk("op_rem", 64'(remainder_bcd), 64'(er));
    chk("op_e0", 64'(err_div0), 64'(e0));
    chk("op_ed", 64'(err_digit), 64'(ed));
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q, dvd;
    logic [15:0] r, dvs;
    logic        e0, ed;
    int          lat, cnt, nd;

    // Model pinned against hand-computed results.
    model_op(32'h12345678, 16'h1234, q, r, e0, ed, lat);
    chk("model_q1", 64'(q), 64'h00010004);
    chk("model_r1", 64'(r), 64'h0742);
    chk("model_l1", 64'(lat), 64'd22);
    model_op(32'h99999999, 16'h0001, q, r, e0, ed, lat);
    chk("model_l2", 64'(lat), 64'd89);
    model_op(32'h99999999, 16'h9999, q, r, e0, ed, lat);
    chk("model_q3", 64'(q), 64'h00010001);
    chk("model_l3", 64'(lat), 64'd19);

    rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_quot", 64'(quotient_bcd), 64'd0);
    chk("rst_rem", 64'({remainder_bcd, err_div0, err_digit, done}), 64'd0);
    rst_n = 1;

    run_op(32'h12345678, 16'h1234, 32'h00010004, 16'h0742, 0, 0, 22);
    run_op(32'h99999999, 16'h0001, 32'h99999999, 16'h0000, 0, 0, 89);
    run_op(32'h00000007, 16'h9999, 32'h00000000, 16'h0007, 0, 0, 17);
    run_op(32'h99999999, 16'h9999, 32'h00010001, 16'h0000, 0, 0, 19);
    run_op(32'h12345678, 16'h0000, 32'h0, 16'h0, 1, 0, 2);
    run_op(32'h12345678, 16'h0001, 32'h12345678, 16'h0, 0, 0, 17 + 36);
    run_op(32'h0000000A, 16'h0001, 32'h0, 16'h0, 0, 1, 2);
    run_op(32'h0000000A, 16'h0000, 32'h0, 16'h0, 1, 1, 2);

    // Reset in the middle of a long division: no done may follow.
    wait_idle();
    dividend_bcd = 32'h99999999; divisor_bcd = 16'h0001; start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (30) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("midrst_quot", 64'(quotient_bcd), 64'd0);
    count_dones(100, cnt);
    chk("midrst_nodone", 64'(cnt), 64'd0);

    // A start while busy is ignored.
    wait_idle();
    dividend_bcd = 32'h12345678; divisor_bcd = 16'h1234; start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (5) @(negedge clk);
    dividend_bcd = 32'h00000007; divisor_bcd = 16'h9999; start = 1;
    @(negedge clk);
    start = 0;
    count_dones(60, cnt);
    chk("busy_start_ignored", 64'(cnt), 64'd1);

    // Start held high: back-to-back 17-cycle divisions, 19-cycle period.
    wait_idle();
    dividend_bcd = 32'h00000007; divisor_bcd = 16'h9999; start = 1;
    count_dones(61, cnt);
    chk("held_start_dones", 64'(cnt), 64'd3);
    start = 0;
    wait_idle();

    for (int k = 0; k < 40; k++) begin
      dvd = '0; dvs = '0;
      for (int i = 0; i < 8; i++) dvd[4*i +: 4] = 4'($urandom_range(0, 9));
      nd = $urandom_range(1, 4);
      for (int i = 0; i < nd; i++) dvs[4*i +: 4] = 4'($urandom_range(0, 9));
      if (dvs == 16'h0) dvs[3:0] = 4'($urandom_range(1, 9));
      model_op(dvd, dvs, q, r, e0, ed, lat);
      run_op(dvd, dvs, q, r, e0, ed, lat);
    end

    wait_idle();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
